// File: rtl/reg_file_mp_if.sv
// Bundled read/write/scoreboard signals between issue, writeback and the
// multi-port register file.
interface reg_file_mp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int NUM_RD     = 3,
    parameter int NUM_WR     = 2,
    localparam int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
);
    logic [NUM_RD*ADDR_W-1:0]     rd_addr;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]            rd_busy;
    logic [NUM_WR-1:0]            wr_en;
    logic [NUM_WR*ADDR_W-1:0]     wr_addr;
    logic [NUM_WR*DATA_WIDTH-1:0] wr_data;
    logic                         sb_set_en;
    logic [ADDR_W-1:0]            sb_set_addr;
    logic                         wr_conflict;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
        input  rd_data, rd_busy, wr_conflict
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
        output rd_data, rd_busy, wr_conflict
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file with write-port priority, conflict flag and busy
// scoreboard. Define REG_FILE_BYPASS_EN to forward same-cycle writes to reads.
module reg_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int NUM_RD     = 3,
    parameter int NUM_WR     = 2,
    parameter int ZERO_REG   = 1,
    localparam int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic         clk,
    input  logic         res,
    reg_file_mp_if.slave bus
);

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      busy_nxt;
    logic                  conflict;
    logic                  conflict_nxt;

    logic [ADDR_W-1:0]     rd_a [NUM_RD];
    logic [ADDR_W-1:0]     wr_a [NUM_WR];
    logic [DATA_WIDTH-1:0] wr_d [NUM_WR];
    logic [NUM_WR-1:0]     wr_ok;
    logic                  set_ok;

    // Valid = inside the array and not the hardwired zero register.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_unpack
        assign rd_a[p] = bus.rd_addr[p*ADDR_W +: ADDR_W];
    end

    for (genvar w = 0; w < NUM_WR; w++) begin : g_wr_unpack
        assign wr_a[w]  = bus.wr_addr[w*ADDR_W +: ADDR_W];
        assign wr_d[w]  = bus.wr_data[w*DATA_WIDTH +: DATA_WIDTH];
        assign wr_ok[w] = bus.wr_en[w] && addr_ok(wr_a[w]);
    end

    assign set_ok = bus.sb_set_en && addr_ok(bus.sb_set_addr);

    always_comb begin
        conflict_nxt = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (wr_ok[i] && wr_ok[j] && (wr_a[i] == wr_a[j])) begin
                    conflict_nxt = 1'b1;
                end
            end
        end
    end

    // Writeback clears first so a same-cycle issue to that register re-marks it busy.
    always_comb begin
        busy_nxt = busy;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_ok[w]) begin
                busy_nxt[wr_a[w]] = 1'b0;
            end
        end
        if (set_ok) begin
            busy_nxt[bus.sb_set_addr] = 1'b1;
        end
    end

    // Ascending loop: the last non-blocking write, i.e. highest port, wins.
    always_ff @(posedge clk) begin
        if (res) begin
            for (int d = 0; d < DEPTH; d++) begin
                regs[d] <= '0;
            end
            busy     <= '0;
            conflict <= 1'b0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_ok[w]) begin
                    regs[wr_a[w]] <= wr_d[w];
                end
            end
            busy     <= busy_nxt;
            conflict <= conflict_nxt;
        end
    end

    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (addr_ok(rd_a[p])) begin
                bus.rd_data[p*DATA_WIDTH +: DATA_WIDTH] = regs[rd_a[p]];
                bus.rd_busy[p] = busy[rd_a[p]];
            end
`ifdef REG_FILE_BYPASS_EN
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_ok[w] && (wr_a[w] == rd_a[p])) begin
                    bus.rd_data[p*DATA_WIDTH +: DATA_WIDTH] = wr_d[w];
                    bus.rd_busy[p] = set_ok && (bus.sb_set_addr == rd_a[p]);
                end
            end
`endif
        end
    end

    assign bus.wr_conflict = conflict;

endmodule

// File: tb/tb_reg_file_mp.sv
// Table-driven bench for reg_file_mp at DEPTH=24; expectations follow
// REG_FILE_BYPASS_EN through the alternate (x*) columns.
module tb_reg_file_mp;

    localparam int DW    = 32;
    localparam int DEPTH = 24;
    localparam int NR    = 3;
    localparam int NW    = 2;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic res;
    always #5 clk = ~clk;

    reg_file_mp_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_RD(NR), .NUM_WR(NW)) bus ();

    reg_file_mp #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1)
    ) dut (
        .clk(clk),
        .res(res),
        .bus(bus)
    );

    typedef struct {
        logic          r;
        logic [1:0]    we;
        logic [AW-1:0] wa0, wa1;
        logic [DW-1:0] wd0, wd1;
        logic          sb;
        logic [AW-1:0] sa;
        logic [AW-1:0] ra0, ra1, ra2;
        logic [DW-1:0] e0, e1, e2;
        logic [2:0]    eb;
        logic          ec;
        logic [DW-1:0] x0, x1, x2;
        logic [2:0]    xb;
    } vec_t;

    vec_t tbl[$];
    vec_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(
        input logic r, input logic [1:0] we,
        input logic [AW-1:0] wa0, input logic [DW-1:0] wd0,
        input logic [AW-1:0] wa1, input logic [DW-1:0] wd1,
        input logic sb, input logic [AW-1:0] sa,
        input logic [AW-1:0] ra0, input logic [AW-1:0] ra1, input logic [AW-1:0] ra2,
        input logic [DW-1:0] e0, input logic [DW-1:0] e1, input logic [DW-1:0] e2,
        input logic [2:0] eb, input logic ec,
        input logic [DW-1:0] x0, input logic [DW-1:0] x1, input logic [DW-1:0] x2,
        input logic [2:0] xb);
        vec_t v;
        v.r = r; v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.sb = sb; v.sa = sa; v.ra0 = ra0; v.ra1 = ra1; v.ra2 = ra2;
        v.e0 = e0; v.e1 = e1; v.e2 = e2; v.eb = eb; v.ec = ec;
        v.x0 = x0; v.x1 = x1; v.x2 = x2; v.xb = xb;
        return v;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.wr_en = '0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.sb_set_en = 1'b0; bus.sb_set_addr = '0; bus.rd_addr = '0;
    endtask

    // One row per cycle: drive after negedge, sample 1ns later, posedge commits.
    task automatic run(input vec_t v, input string tag);
        vec_t e;
        logic [DW-1:0] q0, q1, q2;
        logic [2:0]    qb;
        @(negedge clk);
        res             = v.r;
        bus.wr_en       = v.we;
        bus.wr_addr     = {v.wa1, v.wa0};
        bus.wr_data     = {v.wd1, v.wd0};
        bus.sb_set_en   = v.sb;
        bus.sb_set_addr = v.sa;
        bus.rd_addr     = {v.ra2, v.ra1, v.ra0};
        sbq.push_back(v);
        #1;
        e = sbq.pop_front();
`ifdef REG_FILE_BYPASS_EN
        q0 = e.x0; q1 = e.x1; q2 = e.x2; qb = e.xb;
`else
        q0 = e.e0; q1 = e.e1; q2 = e.e2; qb = e.eb;
`endif
        check({tag, " rd0"}, bus.rd_data[0*DW +: DW], q0);
        check({tag, " rd1"}, bus.rd_data[1*DW +: DW], q1);
        check({tag, " rd2"}, bus.rd_data[2*DW +: DW], q2);
        check({tag, " busy"}, {29'd0, bus.rd_busy}, {29'd0, qb});
        check({tag, " conflict"}, {31'd0, bus.wr_conflict}, {31'd0, e.ec});
    endtask

    initial begin
        res = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);

        //          r  we    wa0 wd0            wa1 wd1        sb sa  ra0 ra1 ra2  e0             e1       e2       eb     ec  x0             x1       x2       xb
        tbl.push_back(mk(0, 2'b01, 5, 32'hDEADBEEF, 0, 0,          0, 0,  5,  0,  1,  0,             0,       0,       3'b000, 0, 32'hDEADBEEF, 0,       0,       3'b000));
        tbl.push_back(mk(0, 2'b00, 0, 0,            0, 0,          0, 0,  5,  0,  1,  32'hDEADBEEF, 0,       0,       3'b000, 0, 32'hDEADBEEF, 0,       0,       3'b000));
        tbl.push_back(mk(1, 2'b01, 5, 32'h77,       0, 0,          1, 5,  6,  1,  2,  0,             0,       0,       3'b000, 0, 0,             0,       0,       3'b000));
        tbl.push_back(mk(0, 2'b00, 0, 0,            0, 0,          0, 0,  5,  0,  1,  0,             0,       0,       3'b000, 0, 0,             0,       0,       3'b000));
        tbl.push_back(mk(0, 2'b11, 3, 32'h11,       7, 32'h22,     0, 0,  3,  7,  0,  0,             0,       0,       3'b000, 0, 32'h11,        32'h22,  0,       3'b000));
        tbl.push_back(mk(0, 2'b00, 0, 0,            0, 0,          0, 0,  3,  7,  0,  32'h11,        32'h22,  0,       3'b000, 0, 32'h11,        32'h22,  0,       3'b000));
        tbl.push_back(mk(0, 2'b11, 4, 32'hAAAA,     4, 32'h5555,   0, 0,  4,  3,  7,  0,             32'h11,  32'h22,  3'b000, 0, 32'h5555,      32'h11,  32'h22,  3'b000));
        tbl.push_back(mk(0, 2'b00, 0, 0,            0, 0,          0, 0,  4,  3,  7,  32'h5555,      32'h11,  32'h22,  3'b000, 1, 32'h5555,      32'h11,  32'h22,  3'b000));
        tbl.push_back(mk(0, 2'b00, 0, 0,            0, 0,          0, 0,  4,  0,  0,  32'h5555,      0,       0,       3'b000, 0, 32'h5555,      0,       0,       3'b000));
        tbl.push_back(mk(0, 2'b01, 0, 32'hFFFF,     0, 0,          0, 0,  0,  1,  2,  0,             0,       0,       3'b000, 0, 0,             0,       0,       3'b000));
        tbl.push_back(mk(0, 2'b11, 0, 32'h1,        0, 32'h2,      0, 0,  0,  1,  2,  0,             0,       0,       3'b000, 0, 0,             0,       0,       3'b000));
        tbl.push_back(mk(0, 2'b00, 0, 0,            0, 0,          0, 0,  0,  1,  2,  0,             0,       0,       3'b000, 0, 0,             0,       0,       3'b000));
        tbl.push_back(mk(0, 2'b00, 0, 0,            0, 0,          1, 9,  9,  0,  1,  0,             0,       0,       3'b000, 0, 0,             0,       0,       3'b000));
        tbl.push_back(mk(0, 2'b00, 0, 0,            0, 0,          0, 0,  9,  0,  1,  0,             0,       0,       3'b001, 0, 0,             0,       0,       3'b001));
        tbl.push_back(mk(0, 2'b01, 9, 32'h99,       0, 0,          1, 9,  9,  0,  1,  0,             0,       0,       3'b001, 0, 32'h99,        0,       0,       3'b001));
        tbl.push_back(mk(0, 2'b00, 0, 0,            0, 0,          0, 0,  9,  0,  1,  32'h99,        0,       0,       3'b001, 0, 32'h99,        0,       0,       3'b001));
        tbl.push_back(mk(0, 2'b10, 0, 0,            9, 32'hA9,     0, 0,  9,  0,  1,  32'h99,        0,       0,       3'b001, 0, 32'hA9,        0,       0,       3'b000));
        tbl.push_back(mk(0, 2'b00, 0, 0,            0, 0,          0, 0,  9,  0,  1,  32'hA9,        0,       0,       3'b000, 0, 32'hA9,        0,       0,       3'b000));
        tbl.push_back(mk(0, 2'b10, 0, 0,            12, 32'h1234,  0, 0,  12, 0,  1,  0,             0,       0,       3'b000, 0, 32'h1234,      0,       0,       3'b000));
        tbl.push_back(mk(0, 2'b00, 0, 0,            0, 0,          0, 0,  12, 0,  1,  32'h1234,      0,       0,       3'b000, 0, 32'h1234,      0,       0,       3'b000));
        tbl.push_back(mk(0, 2'b11, 26, 32'hBAD,     23, 32'h2323,  0, 0,  26, 23, 12, 0,             0,       32'h1234,3'b000, 0, 0,             32'h2323,32'h1234,3'b000));
        tbl.push_back(mk(0, 2'b00, 0, 0,            0, 0,          1, 26, 26, 23, 12, 0,             32'h2323,32'h1234,3'b000, 0, 0,             32'h2323,32'h1234,3'b000));
        tbl.push_back(mk(0, 2'b11, 26, 32'h1,       26, 32'h2,     0, 0,  26, 23, 12, 0,             32'h2323,32'h1234,3'b000, 0, 0,             32'h2323,32'h1234,3'b000));
        tbl.push_back(mk(0, 2'b00, 0, 0,            0, 0,          0, 0,  26, 23, 12, 0,             32'h2323,32'h1234,3'b000, 0, 0,             32'h2323,32'h1234,3'b000));
        tbl.push_back(mk(0, 2'b01, 4, 32'h1,        4, 32'h99999,  0, 0,  4,  0,  1,  32'h5555,      0,       0,       3'b000, 0, 32'h1,         0,       0,       3'b000));
        tbl.push_back(mk(0, 2'b00, 0, 0,            0, 0,          0, 0,  4,  0,  1,  32'h1,         0,       0,       3'b000, 0, 32'h1,         0,       0,       3'b000));

        foreach (tbl[i]) begin
            run(tbl[i], $sformatf("row%0d", i));
        end

        // Back-to-back conflicts keep the flag high for two cycles, then it drops.
        run(mk(0, 2'b11, 2, 32'h1, 2, 32'h2, 0, 0, 2, 0, 1, 0,     0, 0, 3'b000, 0, 32'h2, 0, 0, 3'b000), "bb0");
        run(mk(0, 2'b11, 2, 32'h3, 2, 32'h4, 0, 0, 2, 0, 1, 32'h2, 0, 0, 3'b000, 1, 32'h4, 0, 0, 3'b000), "bb1");
        run(mk(0, 2'b00, 0, 0,     0, 0,     0, 0, 2, 0, 1, 32'h4, 0, 0, 3'b000, 1, 32'h4, 0, 0, 3'b000), "bb2");
        run(mk(0, 2'b00, 0, 0,     0, 0,     0, 0, 2, 0, 1, 32'h4, 0, 0, 3'b000, 0, 32'h4, 0, 0, 3'b000), "bb3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
